// File: rtl/sort_mem_arbiter.sv
// Two-port arbiter for the single-port sort memory: registered round-robin grant,
// lock for atomic swap bursts, bounded hold so the waiting side cannot starve.
module sort_mem_arbiter #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          h_req,
    input  logic          h_lock,
    input  logic          h_rd,
    input  logic          h_wr,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic [DW-1:0] h_rdata,
    output logic          h_rvalid,
    input  logic          s_req,
    input  logic          s_lock,
    input  logic          s_rd,
    input  logic          s_wr,
    input  logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_wdata,
    output logic          s_gnt,
    output logic [DW-1:0] s_rdata,
    output logic          s_rvalid,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          preempt,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, GNT_H, GNT_S} state_t;

    localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_TOP = CW'(MAX_HOLD - 1);

    state_t          state, nxt, other;
    logic            last_s;
    logic [CW-1:0]   hold_cnt;
    logic            x_req, y_req, x_lock, x_rd, x_wr;
    logic [AW-1:0]   x_addr;
    logic [DW-1:0]   x_wdata;

    assign h_gnt = (state == GNT_H);
    assign s_gnt = (state == GNT_S);
    assign busy  = h_gnt | s_gnt;
    assign other = h_gnt ? GNT_S : GNT_H;
    assign y_req = h_gnt ? s_req : h_req;

    // Owner-side view; everything reads as zero while idle.
    always_comb begin
        x_req = 1'b0; x_lock = 1'b0; x_rd = 1'b0; x_wr = 1'b0;
        x_addr = '0; x_wdata = '0;
        if (h_gnt) begin
            x_req = h_req; x_lock = h_lock; x_rd = h_rd; x_wr = h_wr;
            x_addr = h_addr; x_wdata = h_wdata;
        end else if (s_gnt) begin
            x_req = s_req; x_lock = s_lock; x_rd = s_rd; x_wr = s_wr;
            x_addr = s_addr; x_wdata = s_wdata;
        end
    end

    assign mem_rd    = x_rd & ~x_wr;
    assign mem_wr    = x_wr & ~x_rd;
    assign mem_addr  = x_addr;
    assign mem_wdata = x_wdata;
    assign err       = x_rd & x_wr;

    always_comb begin
        nxt     = state;
        preempt = 1'b0;
        case (state)
            IDLE: begin
                if (h_req && s_req) nxt = last_s ? GNT_H : GNT_S;
                else if (h_req)     nxt = GNT_H;
                else if (s_req)     nxt = GNT_S;
            end
            default: begin
                if (!x_req) begin
                    nxt = y_req ? other : IDLE;
                end else if (y_req && (!x_lock || hold_cnt == HOLD_TOP)) begin
                    nxt     = other;
                    preempt = x_lock;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_s   <= 1'b1;
            hold_cnt <= '0;
            h_rvalid <= 1'b0;
            s_rvalid <= 1'b0;
            h_rdata  <= '0;
            s_rdata  <= '0;
        end else begin
            state <= nxt;
            if (busy && nxt != state) last_s <= s_gnt;
            // Hold time only accrues while the other side is actually waiting.
            if (nxt != state || nxt == IDLE) hold_cnt <= '0;
            else if (y_req && hold_cnt != HOLD_TOP) hold_cnt <= hold_cnt + 1'b1;
            h_rvalid <= h_gnt & mem_rd;
            s_rvalid <= s_gnt & mem_rd;
            if (h_gnt && mem_rd) h_rdata <= mem_rdata;
            if (s_gnt && mem_rd) s_rdata <= mem_rdata;
        end
    end
endmodule

// File: doc/sort_mem_arbiter.md
Name: sort_mem_arbiter

Overview:
- Shares the single-port sort memory between two requesters: the host port (load and readback) and the sort-engine port (compare/swap sequences).
- Performs registered round-robin arbitration with a lock for atomic read-read-write-write swap bursts.
- Enforces a bounded hold time so neither requester starves.
- Sits between the sort controller/datapath, the host loader and the memory array. Memory read is combinational.

Parameters:
- AW, 4, memory address width.
- DW, 8, data width.
- MAX_HOLD, 16, maximum consecutive granted cycles under lock while the other side is pending (must be ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- h_req  in  1  host requests the memory.
- h_lock  in  1  host asks to keep the grant across cycles.
- h_rd  in  1  host read strobe, valid only while h_gnt=1.
- h_wr  in  1  host write strobe, valid only while h_gnt=1.
- h_addr  in  AW  host address.
- h_wdata  in  DW  host write data.
- h_gnt  out  1  host owns the memory this cycle.
- h_rdata  out  DW  registered host read data.
- h_rvalid  out  1  one-cycle pulse: h_rdata updated.
- s_req, s_lock, s_rd, s_wr, s_addr, s_wdata  in  1,1,1,1,AW,DW  sort-engine equivalents of the host inputs.
- s_gnt, s_rdata, s_rvalid  out  1,DW,1  sort-engine equivalents of the host outputs.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  combinational memory read data.
- busy  out  1  some requester is granted.
- preempt  out  1  one-cycle pulse on a forced hold-limit handoff.
- err  out  1  one-cycle pulse: owner asserted rd and wr together.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - state=IDLE; last_owner=SORT, so the host wins the first tie; hold_cnt=0.
  - h_gnt=s_gnt=0, h_rvalid=s_rvalid=0, h_rdata=s_rdata=0.
  - preempt=0, err=0.
  - mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset mid-grant drops the grant immediately. Any in-flight read is discarded (no rvalid).
- States: IDLE, GNT_H, GNT_S. Grant outputs are decoded from the registered state: h_gnt=(state==GNT_H), s_gnt=(state==GNT_S).
- Latency: request seen at edge N → grant visible in cycle N+1. An access requires the grant in the same cycle.
- IDLE transitions:
  - Only h_req → GNT_H.
  - Only s_req → GNT_S.
  - Both → the side that is not last_owner.
  - Neither → stay in IDLE.
- GNT_X, evaluated each cycle (Y is the other side):
  - X_req=0: go to GNT_Y if Y_req, else IDLE. No bubble cycle.
  - X_req=1, Y_req=0: stay.
  - X_req=1, Y_req=1, X_lock=0: go to GNT_Y.
  - X_req=1, Y_req=1, X_lock=1, hold_cnt<MAX_HOLD-1: stay.
  - X_req=1, Y_req=1, X_lock=1, hold_cnt==MAX_HOLD-1: go to GNT_Y, with preempt=1 in that cycle.
  - On any GNT_X → other-state transition, last_owner←X.
- hold_cnt:
  - Clears on entry to any grant state and in IDLE.
  - Increments each cycle the grant is kept.
  - Saturates at MAX_HOLD-1.
  - Counts only while Y_req=1; holds its value otherwise.
- Memory mux (combinational, owner only):
  - mem_rd = gnt & rd & ~wr.
  - mem_wr = gnt & wr & ~rd.
  - mem_addr/mem_wdata come from the owner; they are 0 in IDLE.
  - Strobes from the non-owner are ignored.
- Owner with rd=wr=1: no memory access; err=1 for that cycle.
- Read return: on mem_rd by X at edge N, X_rdata←mem_rdata and X_rvalid=1 during cycle N+1. X_rdata holds until X's next read. The path is independent of any grant change at edge N.
- The owner's access in its last granted cycle completes normally.
- busy = h_gnt | s_gnt.

Test Plan:
- Reset hold: rst_n=0 with random inputs → all outputs 0. Release with only h_req=1 → h_gnt=1 one cycle later.
- Host load/readback:
  - Host writes 0x5A to addr 3: mem_wr=1, mem_addr=3, mem_wdata=0x5A.
  - Next cycle host reads addr 3 with mem_rdata=0x5A → h_rvalid pulses next cycle and h_rdata=0x5A.
- Tie and alternation: h_req and s_req both held high, locks low from reset → grants alternate H,S,H,S every cycle; preempt stays 0.
- Lock limit:
  - Sorter granted with s_lock=1 and s_req=1, host requesting, MAX_HOLD=16 → s_gnt holds exactly 16 cycles.
  - preempt pulses in the 16th cycle; h_gnt=1 the next cycle.
- Handoff without bubble: host owns, h_req drops while s_req=1 → s_gnt=1 the next cycle and busy never drops.
- Error and mid-reset:
  - Owner asserts rd=wr=1 → mem_rd=mem_wr=0 and err pulses.
  - rst_n asserted mid-read → no rvalid; state IDLE.
